// File: rtl/spi_frame_rx.sv
// spi_frame_rx: clk-domain oversampled SPI mode-0 slave that writes one NPIX-byte frame per CE-low window.
// Define SPI_RX_ECHO_EN to build the sdo echo of the previously completed byte; otherwise sdo is tied 0.
module spi_frame_rx #(
    parameter int NPIX = 64,
    parameter int PIXW = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    spi_sck,
    input  logic                    sdi,
    input  logic                    CE,
    output logic                    sdo,
    output logic                    wr_en,
    output logic [$clog2(NPIX)-1:0] wr_addr,
    output logic [PIXW-1:0]         wr_data,
    output logic                    frame_done,
    output logic                    frame_err,
    output logic                    busy
);
    localparam int AW = $clog2(NPIX);
    localparam logic [AW:0] FULL     = (AW+1)'(NPIX);
    localparam logic [AW:0] BYTE_ONE = (AW+1)'(1);
`ifdef SPI_RX_ECHO_EN
    localparam int SW = 8;
`else
    localparam int SW = PIXW;
`endif

    typedef enum logic [1:0] {WAIT_HI, IDLE, RECV} state_t;

    logic          sck_p0, sck_p1, sck_p2;
    logic          ce_p0, ce_p1, ce_p2;
    logic          sdi_p0, sdi_p1;
    logic          sck_rise, ce_fall, ce_rise;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [AW:0]   byte_cnt_q, byte_cnt_d;
    logic          ovf_q, ovf_d;
    logic [SW-2:0] shift_q, shift_d;
    logic [SW-1:0] new_byte;
    logic          byte_wrap;
    logic          wr_en_d, done_d, err_d;
    logic [AW-1:0] wr_addr_d;
    logic [PIXW-1:0] wr_data_d;

    // Stage p0/p1: two-flop synchronisers; p2 plus the edge registers give one-cycle edge pulses.
    // The sck/CE chains reset low so a CE held low through reset never looks like a fresh edge.
    always_ff @(posedge clk) begin
        sdi_p0 <= sdi;
        sdi_p1 <= sdi_p0;
        if (!reset) begin
            sck_p0   <= 1'b0;
            sck_p1   <= 1'b0;
            sck_p2   <= 1'b0;
            ce_p0    <= 1'b0;
            ce_p1    <= 1'b0;
            ce_p2    <= 1'b0;
            sck_rise <= 1'b0;
            ce_fall  <= 1'b0;
            ce_rise  <= 1'b0;
        end else begin
            sck_p0   <= spi_sck;
            sck_p1   <= sck_p0;
            sck_p2   <= sck_p1;
            ce_p0    <= CE;
            ce_p1    <= ce_p0;
            ce_p2    <= ce_p1;
            sck_rise <= sck_p1 & ~sck_p2;
            ce_fall  <= ~ce_p1 & ce_p2;
            ce_rise  <= ce_p1 & ~ce_p2;
        end
    end

    assign new_byte  = {shift_q, sdi_p1};
    assign byte_wrap = (state_q == RECV) && sck_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        ovf_d      = ovf_q;
        shift_d    = shift_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            WAIT_HI: begin
                if (ce_p1) state_d = IDLE;
            end
            IDLE: begin
                if (ce_fall) begin
                    state_d    = RECV;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            RECV: begin
                if (sck_rise) begin
                    shift_d   = new_byte[SW-2:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (byte_wrap) begin
                        if (!byte_cnt_q[AW]) begin
                            wr_en_d    = 1'b1;
                            wr_addr_d  = byte_cnt_q[AW-1:0];
                            wr_data_d  = new_byte[PIXW-1:0];
                            byte_cnt_d = byte_cnt_q + BYTE_ONE;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                // Completion uses the post-sck counts so a last bit landing on the CE edge still counts.
                if (ce_rise) begin
                    state_d = IDLE;
                    if (byte_cnt_d == FULL && bit_cnt_d == 3'd0 && !ovf_d) done_d = 1'b1;
                    else                                                 err_d  = 1'b1;
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    // Stage p3: frame state and registered write/status outputs.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (!reset) begin
            state_q    <= WAIT_HI;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            ovf_q      <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            ovf_q      <= ovf_d;
            wr_en      <= wr_en_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            frame_done <= done_d;
            frame_err  <= err_d;
        end
    end

    assign busy = (state_q == RECV);

`ifdef SPI_RX_ECHO_EN
    logic       sck_fall;
    logic       sdo_q;
    logic [7:0] echo_q;

    always_ff @(posedge clk) begin
        if (!reset) sck_fall <= 1'b0;
        else        sck_fall <= ~sck_p1 & sck_p2;
    end

    // Echo byte is cleared at frame start so the first byte of every frame shifts out zeros.
    always_ff @(posedge clk) begin
        if (!reset)                          sdo_q <= 1'b0;
        else if (state_q == IDLE && ce_fall) sdo_q <= 1'b0;
        else if (state_q == RECV && sck_fall) sdo_q <= echo_q[7];

        if (state_q == IDLE && ce_fall)       echo_q <= 8'h00;
        else if (byte_wrap)                   echo_q <= new_byte;
        else if (state_q == RECV && sck_fall) echo_q <= {echo_q[6:0], 1'b0};
    end

    assign sdo = sdo_q;
`else
    assign sdo = 1'b0;
`endif

endmodule
